wired_inst_queue: RTL and testbench

//  Decoupling FIFO between the front-end decode stage and the backend rename stage.

---
 rtl/wired_inst_queue_pkg.sv | 23 ++
 rtl/wired_queue_ram.sv | 34 +++
 rtl/wired_inst_queue.sv | 117 +++++++++++
 tb/tb_wired_inst_queue.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/wired_inst_queue_pkg.sv
// Shared types for the instruction queue between decode and rename.
package wired_inst_queue_pkg;

  // Decoded instruction as carried down the pipeline.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd_addr;
    logic        rd_we;
  } pipeline_ctrl_pack_t;

  localparam int IQ_DEPTH = 8;
  localparam int IQ_PTR_W = $clog2(IQ_DEPTH) + 1;

  // Queue pointer: index bits plus one wrap bit, so full and empty differ.
  typedef logic [IQ_PTR_W-1:0] iq_ptr_t;

  // Number of set bits in a 2-slot mask.
  function automatic logic [1:0] popcnt2(input logic [1:0] m);
    return {1'b0, m[0]} + {1'b0, m[1]};
  endfunction

endpackage

// File: rtl/wired_queue_ram.sv
// DEPTH-entry storage with two address-indexed write ports and two
// combinational read ports. The two write addresses are always distinct
// when both enables are high.
module wired_queue_ram
  import wired_inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we0,
  input  logic [AW-1:0]       waddr0,
  input  pipeline_ctrl_pack_t wdata0,
  input  logic                we1,
  input  logic [AW-1:0]       waddr1,
  input  pipeline_ctrl_pack_t wdata1,
  input  logic [AW-1:0]       raddr0,
  output pipeline_ctrl_pack_t rdata0,
  input  logic [AW-1:0]       raddr1,
  output pipeline_ctrl_pack_t rdata1
);

  pipeline_ctrl_pack_t mem [DEPTH];

  // Payload writes; entries carry no reset since occupancy lives in the pointers.
  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/wired_inst_queue.sv
// Decoupling queue between front-end decode and backend rename.
// Accepts up to two instructions per cycle, presents the oldest one or two
// compacted into slots 0/1, and empties completely on a backend flush.
module wired_inst_queue
  import wired_inst_queue_pkg::*;
#(
  // Must match IQ_DEPTH, which sizes iq_ptr_t.
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [1:0]                in_mask_i,
  input  pipeline_ctrl_pack_t [1:0] in_pkg_i,
  output logic                      pkg_valid_o,
  input  logic                      pkg_ready_i,
  output logic [1:0]                pkg_mask_o,
  output pipeline_ctrl_pack_t [1:0] pkg_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int AW = $clog2(DEPTH);

  iq_ptr_t             rd_ptr;
  iq_ptr_t             wr_ptr;
  iq_ptr_t             count;
  logic                wr_fire;
  logic                rd_fire;
  logic [AW-1:0]       waddr0;
  logic [AW-1:0]       waddr1;
  logic [AW-1:0]       raddr0;
  logic [AW-1:0]       raddr1;
  logic                we0;
  logic                we1;
  pipeline_ctrl_pack_t wdata0;
  pipeline_ctrl_pack_t wdata1;

  // Occupancy from the wrap-bit pointers; modular subtraction handles wrap.
  assign count   = wr_ptr - rd_ptr;
  assign count_o = count;

  // Ready depends only on registered state so it never combinationally
  // follows the front-end valid; room for a full 2-slot packet is required.
  assign in_ready_o = (count <= iq_ptr_t'(DEPTH - 2));
  assign wr_fire    = in_valid_i & in_ready_o & ~flush_i;

  // Output side: no bypass, everything comes from stored entries.
  assign pkg_valid_o = (count != '0);
  assign pkg_mask_o  = {count >= iq_ptr_t'(2), pkg_valid_o};
  assign rd_fire     = pkg_valid_o & pkg_ready_i & ~flush_i;

  // Slot-1 addresses wrap on their own within the index bits.
  assign waddr0 = wr_ptr[AW-1:0];
  assign waddr1 = waddr0 + AW'(1);
  assign raddr0 = rd_ptr[AW-1:0];
  assign raddr1 = raddr0 + AW'(1);

  // Compaction: the oldest valid incoming slot always lands at wr_ptr.
  always_comb begin
    we0    = 1'b0;
    we1    = 1'b0;
    wdata0 = in_pkg_i[0];
    wdata1 = in_pkg_i[1];
    if (wr_fire) begin
      unique case (in_mask_i)
        2'b01: we0 = 1'b1;
        2'b10: begin
          we0    = 1'b1;
          wdata0 = in_pkg_i[1];
        end
        2'b11: begin
          we0 = 1'b1;
          we1 = 1'b1;
        end
        default: ;
      endcase
    end
  end

  wired_queue_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk    (clk),
    .we0    (we0),
    .waddr0 (waddr0),
    .wdata0 (wdata0),
    .we1    (we1),
    .waddr1 (waddr1),
    .wdata1 (wdata1),
    .raddr0 (raddr0),
    .rdata0 (pkg_o[0]),
    .raddr1 (raddr1),
    .rdata1 (pkg_o[1])
  );

  // Pointer update: flush discards everything and overrides both handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush_i) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + iq_ptr_t'(popcnt2(in_mask_i));
      if (rd_fire) rd_ptr <= rd_ptr + iq_ptr_t'(popcnt2(pkg_mask_o));
    end
  end

  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    count <= iq_ptr_t'(DEPTH));

  a_mask_idle : assert property (@(posedge clk) disable iff (!rst_n)
    !pkg_valid_o |-> (pkg_mask_o == 2'b00));

endmodule

// File: tb/tb_wired_inst_queue.sv
// Directed bench for wired_inst_queue with a queue-based scoreboard.
module tb_wired_inst_queue;
  import wired_inst_queue_pkg::*;

  localparam int DEPTH = 8;

  logic                      clk;
  logic                      rst_n;
  logic                      flush_i;
  logic                      in_valid_i;
  logic                      in_ready_o;
  logic [1:0]                in_mask_i;
  pipeline_ctrl_pack_t [1:0] in_pkg_i;
  logic                      pkg_valid_o;
  logic                      pkg_ready_i;
  logic [1:0]                pkg_mask_o;
  pipeline_ctrl_pack_t [1:0] pkg_o;
  logic [$clog2(DEPTH):0]    count_o;

  wired_inst_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_mask_i   (in_mask_i),
    .in_pkg_i    (in_pkg_i),
    .pkg_valid_o (pkg_valid_o),
    .pkg_ready_i (pkg_ready_i),
    .pkg_mask_o  (pkg_mask_o),
    .pkg_o       (pkg_o),
    .count_o     (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int next_id  = 1;
  int rdm      = 0;
  pipeline_ctrl_pack_t sb[$];
  pipeline_ctrl_pack_t nul = '0;

  function automatic pipeline_ctrl_pack_t mk(input int id);
    pipeline_ctrl_pack_t p;
    p.pc      = 32'h1000 + 32'(id) * 4;
    p.inst    = 32'(id) ^ 32'hA5A5_0000;
    p.rd_addr = 5'(id);
    p.rd_we   = id[0];
    return p;
  endfunction

  function automatic pipeline_ctrl_pack_t nxt();
    next_id++;
    return mk(next_id);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all visible outputs with the scoreboard's view of the queue.
  task automatic check_outputs();
    int n;
    n = sb.size();
    chk("count", 128'(count_o), 128'(n));
    chk("valid", 128'(pkg_valid_o), 128'(n != 0));
    chk("mask", 128'(pkg_mask_o), 128'({n >= 2, n >= 1}));
    chk("in_ready", 128'(in_ready_o), 128'(DEPTH - n >= 2));
    if (n >= 1) chk("slot0", 128'(pkg_o[0]), 128'(sb[0]));
    if (n >= 2) chk("slot1", 128'(pkg_o[1]), 128'(sb[1]));
  endtask

  // One clock of stimulus; entered and left at posedge+1.
  task automatic step(input logic v, input logic [1:0] m,
                      input pipeline_ctrl_pack_t p0, input pipeline_ctrl_pack_t p1,
                      input logic rdy, input logic fl);
    int  n;
    int  out_n;
    bit  acc;
    check_outputs();
    in_valid_i  = v;
    in_mask_i   = m;
    in_pkg_i[0] = p0;
    in_pkg_i[1] = p1;
    pkg_ready_i = rdy;
    flush_i     = fl;
    n     = sb.size();
    acc   = v && (DEPTH - n >= 2) && !fl;
    out_n = (!fl && rdy && n > 0) ? ((n >= 2) ? 2 : 1) : 0;
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
    end else begin
      repeat (out_n) void'(sb.pop_front());
      rdm += out_n;
      if (acc) begin
        if (m[0]) sb.push_back(p0);
        if (m[1]) sb.push_back(p1);
      end
    end
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 2'b00, nul, nul, rdy, 1'b0);
  endtask

  task automatic push2(input logic rdy);
    pipeline_ctrl_pack_t a;
    pipeline_ctrl_pack_t b;
    a = nxt();
    b = nxt();
    step(1'b1, 2'b11, a, b, rdy, 1'b0);
  endtask

  task automatic drain();
    for (int g = 0; g < 10 && sb.size() != 0; g++) idle(1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pipeline_ctrl_pack_t a;
    pipeline_ctrl_pack_t b;
    rst_n       = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_mask_i   = 2'b00;
    in_pkg_i    = '0;
    pkg_ready_i = 1'b0;
    #2;
    check_outputs();
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: one 2-slot packet, visible next cycle, consumed at once
    a = nxt();
    b = nxt();
    step(1'b1, 2'b11, a, b, 1'b1, 1'b0);
    chk("t1_slot0", 128'(pkg_o[0]), 128'(a));
    chk("t1_slot1", 128'(pkg_o[1]), 128'(b));
    idle(1'b1);
    idle(1'b1);

    // 2: compaction of a slot-1-only packet followed by a slot-0-only packet
    a = nxt();
    step(1'b1, 2'b10, nul, a, 1'b0, 1'b0);
    b = nxt();
    step(1'b1, 2'b01, b, nul, 1'b0, 1'b0);
    chk("t2_count", 128'(count_o), 128'(2));
    chk("t2_slot0", 128'(pkg_o[0]), 128'(a));
    chk("t2_slot1", 128'(pkg_o[1]), 128'(b));
    drain();

    // 3: fill to DEPTH, then to DEPTH-1; rejected packets must be dropped
    repeat (4) push2(1'b0);
    chk("t3_full_ready", 128'(in_ready_o), 128'(0));
    push2(1'b0);
    drain();
    repeat (3) push2(1'b0);
    a = nxt();
    step(1'b1, 2'b01, a, nul, 1'b0, 1'b0);
    chk("t3_cnt7", 128'(count_o), 128'(7));
    chk("t3_cnt7_ready", 128'(in_ready_o), 128'(0));
    push2(1'b0);
    drain();

    // 4: steady 2-in/2-out stream across pointer wrap
    repeat (20) push2(1'b1);
    drain();
    for (int g = 0; g < 20 && (rdm % DEPTH) != DEPTH - 1; g++) begin
      a = nxt();
      step(1'b1, 2'b01, a, nul, 1'b1, 1'b0);
    end
    for (int g = 0; g < 4 && sb.size() < 2; g++) begin
      a = nxt();
      step(1'b1, 2'b01, a, nul, 1'b0, 1'b0);
    end
    idle(1'b0);
    drain();

    // 5: flush with both handshakes active at count 5
    push2(1'b0);
    push2(1'b0);
    a = nxt();
    step(1'b1, 2'b01, a, nul, 1'b0, 1'b0);
    chk("t5_cnt5", 128'(count_o), 128'(5));
    a = nxt();
    b = nxt();
    step(1'b1, 2'b11, a, b, 1'b1, 1'b1);
    chk("t5_post_count", 128'(count_o), 128'(0));
    chk("t5_post_valid", 128'(pkg_valid_o), 128'(0));
    push2(1'b0);
    idle(1'b1);
    idle(1'b1);

    // 6: asynchronous reset between clock edges
    push2(1'b0);
    push2(1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_count", 128'(count_o), 128'(0));
    chk("t6_valid", 128'(pkg_valid_o), 128'(0));
    chk("t6_mask", 128'(pkg_mask_o), 128'(0));
    chk("t6_ready", 128'(in_ready_o), 128'(1));
    sb.delete();
    rdm = 0;
    #2;
    rst_n = 1'b1;
    push2(1'b0);
    idle(1'b1);
    idle(1'b1);
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
